// File: rtl/axi_read_arbiter_tag_fifo.sv
// In-order tag FIFO for the read arbiter: one entry per accepted burst,
// holding {requester index, original ARID}. Head is visible combinationally.
module axi_read_arbiter_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge ap_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin AXI4 read arbiter: NUM_PORTS requesters share one read master.
// All bursts go out with ARID 0, so R returns in issue order and is steered
// back via an in-order tag FIFO that also restores the requester's ARID.
module axi_read_arbiter #(
  parameter int NUM_PORTS           = 4,
  parameter int C_M_AXI_ID_WIDTH    = 8,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int MAX_OUTSTANDING     = 16
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst,
  input  logic [NUM_PORTS-1:0]                   in_ARVALID,
  output logic [NUM_PORTS-1:0]                   in_ARREADY,
  input  logic [NUM_PORTS*C_M_AXI_ADDR_WIDTH-1:0] in_ARADDR,
  input  logic [NUM_PORTS*8-1:0]                 in_ARLEN,
  input  logic [NUM_PORTS*3-1:0]                 in_ARSIZE,
  input  logic [NUM_PORTS*2-1:0]                 in_ARBURST,
  input  logic [NUM_PORTS*C_M_AXI_ID_WIDTH-1:0]  in_ARID,
  output logic [NUM_PORTS-1:0]                   in_RVALID,
  input  logic [NUM_PORTS-1:0]                   in_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          in_RDATA,
  output logic                                   in_RLAST,
  output logic [1:0]                             in_RRESP,
  output logic [C_M_AXI_ID_WIDTH-1:0]            in_RID,
  output logic                                   out_ARVALID,
  input  logic                                   out_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          out_ARADDR,
  output logic [7:0]                             out_ARLEN,
  output logic [2:0]                             out_ARSIZE,
  output logic [1:0]                             out_ARBURST,
  output logic [C_M_AXI_ID_WIDTH-1:0]            out_ARID,
  input  logic                                   out_RVALID,
  output logic                                   out_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          out_RDATA,
  input  logic                                   out_RLAST,
  input  logic [1:0]                             out_RRESP,
  input  logic [C_M_AXI_ID_WIDTH-1:0]            out_RID
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ID_W   = C_M_AXI_ID_WIDTH;
  localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
  localparam int TAG_W  = IDX_W + ID_W;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             gnt_valid;
  logic             slot_free;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic [TAG_W-1:0] fifo_head;
  logic [TAG_W-1:0] fifo_push_data;
  logic [IDX_W-1:0] head_idx;
  logic             rid_unused;

  assign slot_free = !out_ARVALID || out_ARREADY;
  assign out_ARID  = '0;

  // Round-robin grant: first valid requester at or above ptr, wrapping.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    cand       = 0;
    cand_idx   = '0;
    in_ARREADY = '0;
    if (slot_free && !fifo_full) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand     = (32'(ptr) + i) % NUM_PORTS;
        cand_idx = IDX_W'(cand);
        if (!gnt_valid && in_ARVALID[cand_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
    if (gnt_valid) in_ARREADY[gnt_idx] = 1'b1;
    next_ptr = IDX_W'((32'(gnt_idx) + 1) % NUM_PORTS);
  end

  // AR output register and priority pointer; pointer moves only on accept.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_ARVALID <= 1'b0;
      out_ARADDR  <= '0;
      out_ARLEN   <= '0;
      out_ARSIZE  <= '0;
      out_ARBURST <= '0;
      ptr         <= '0;
    end else if (gnt_valid) begin
      out_ARVALID <= 1'b1;
      out_ARADDR  <= in_ARADDR[gnt_idx*ADDR_W +: ADDR_W];
      out_ARLEN   <= in_ARLEN[gnt_idx*8 +: 8];
      out_ARSIZE  <= in_ARSIZE[gnt_idx*3 +: 3];
      out_ARBURST <= in_ARBURST[gnt_idx*2 +: 2];
      ptr         <= next_ptr;
    end else if (out_ARREADY) begin
      out_ARVALID <= 1'b0;
    end
  end

  assign fifo_push_data = {gnt_idx, in_ARID[gnt_idx*ID_W +: ID_W]};

  axi_read_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .push      (gnt_valid),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_idx   = fifo_head[TAG_W-1 -: IDX_W];
  assign in_RID     = fifo_head[ID_W-1:0];
  assign in_RDATA   = out_RDATA;
  assign in_RLAST   = out_RLAST;
  assign in_RRESP   = out_RRESP;
  assign out_RREADY = !fifo_empty && in_RREADY[head_idx];
  assign fifo_pop   = out_RVALID && out_RREADY && out_RLAST;
  assign rid_unused = ^{out_RID, fifo_count};

  // R steering: only the head-tag requester sees RVALID; nothing when empty.
  always_comb begin
    in_RVALID = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (head_idx == IDX_W'(i)) in_RVALID[i] = out_RVALID && !fifo_empty;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed scoreboard bench for axi_read_arbiter: the stimulus thread pushes
// expected AR payloads and R deliveries; monitors pop and compare on handshakes.
module tb_axi_read_arbiter;

  localparam int NP  = 4;
  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int DW  = 512;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [NP-1:0]     in_ARVALID;
  logic [NP-1:0]     in_ARREADY;
  logic [NP*AW-1:0]  in_ARADDR;
  logic [NP*8-1:0]   in_ARLEN;
  logic [NP*3-1:0]   in_ARSIZE;
  logic [NP*2-1:0]   in_ARBURST;
  logic [NP*IDW-1:0] in_ARID;
  logic [NP-1:0]     in_RVALID;
  logic [NP-1:0]     in_RREADY;
  logic [DW-1:0]     in_RDATA;
  logic              in_RLAST;
  logic [1:0]        in_RRESP;
  logic [IDW-1:0]    in_RID;
  logic              out_ARVALID;
  logic              out_ARREADY;
  logic [AW-1:0]     out_ARADDR;
  logic [7:0]        out_ARLEN;
  logic [2:0]        out_ARSIZE;
  logic [1:0]        out_ARBURST;
  logic [IDW-1:0]    out_ARID;
  logic              out_RVALID;
  logic              out_RREADY;
  logic [DW-1:0]     out_RDATA;
  logic              out_RLAST;
  logic [1:0]        out_RRESP;
  logic [IDW-1:0]    out_RID;

  axi_read_arbiter #(
    .NUM_PORTS          (NP),
    .C_M_AXI_ID_WIDTH   (IDW),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .MAX_OUTSTANDING    (16)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_ARVALID  (in_ARVALID),
    .in_ARREADY  (in_ARREADY),
    .in_ARADDR   (in_ARADDR),
    .in_ARLEN    (in_ARLEN),
    .in_ARSIZE   (in_ARSIZE),
    .in_ARBURST  (in_ARBURST),
    .in_ARID     (in_ARID),
    .in_RVALID   (in_RVALID),
    .in_RREADY   (in_RREADY),
    .in_RDATA    (in_RDATA),
    .in_RLAST    (in_RLAST),
    .in_RRESP    (in_RRESP),
    .in_RID      (in_RID),
    .out_ARVALID (out_ARVALID),
    .out_ARREADY (out_ARREADY),
    .out_ARADDR  (out_ARADDR),
    .out_ARLEN   (out_ARLEN),
    .out_ARSIZE  (out_ARSIZE),
    .out_ARBURST (out_ARBURST),
    .out_ARID    (out_ARID),
    .out_RVALID  (out_RVALID),
    .out_RREADY  (out_RREADY),
    .out_RDATA   (out_RDATA),
    .out_RLAST   (out_RLAST),
    .out_RRESP   (out_RRESP),
    .out_RID     (out_RID)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          port;
    logic [7:0]  id;
  } tag_t;

  typedef struct {
    int          port;
    logic [7:0]  id;
    logic [DW-1:0] data;
    logic        last;
  } rexp_t;

  logic [52:0] exp_ar[$];
  rexp_t       exp_r[$];
  tag_t        tagq[$];

  logic [31:0] addr_a [NP];
  logic [7:0]  len_a  [NP];
  logic [7:0]  id_a   [NP];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic req(input int p, input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    addr_a[p] = addr;
    len_a[p]  = len;
    id_a[p]   = id;
    in_ARVALID[p]          = 1'b1;
    in_ARADDR[p*AW +: AW]  = addr;
    in_ARLEN[p*8 +: 8]     = len;
    in_ARSIZE[p*3 +: 3]    = 3'(p);
    in_ARBURST[p*2 +: 2]   = 2'(p % 3);
    in_ARID[p*IDW +: IDW]  = id;
  endtask

  // p < 0 means no grant is expected this cycle.
  task automatic expect_grant(input int p);
    logic [NP-1:0] e;
    #1;
    e = '0;
    if (p >= 0) e[p] = 1'b1;
    chk("ar_grant", in_ARREADY, e);
    if (p >= 0) begin
      exp_ar.push_back({addr_a[p], len_a[p], 3'(p), 2'(p % 3), 8'h00});
      tagq.push_back('{p, id_a[p]});
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] data, input logic last);
    logic [NP-1:0] e;
    out_RVALID = 1'b1;
    out_RDATA  = data;
    out_RLAST  = last;
    out_RRESP  = 2'b00;
    #1;
    if (tagq.size() == 0) begin
      chk("r_tag_avail", 0, 1);
    end else begin
      e = '0;
      e[tagq[0].port] = 1'b1;
      chk("r_route", in_RVALID, e);
      exp_r.push_back('{tagq[0].port, tagq[0].id, data, last});
      if (last) void'(tagq.pop_front());
    end
  endtask

  // AR monitor: every master-side handshake must match the next expected payload.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_ARVALID && out_ARREADY) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else chk("ar_payload", {out_ARADDR, out_ARLEN, out_ARSIZE, out_ARBURST, out_ARID}, exp_ar.pop_front());
    end
  end

  // R monitor: every requester-side beat must match the next expected delivery.
  always @(negedge ap_clk) begin
    rexp_t e;
    if (!ap_rst) begin
      for (int i = 0; i < NP; i++) begin
        if (in_RVALID[i] && in_RREADY[i]) begin
          if (exp_r.size() == 0) begin
            chk("r_unexpected", 1, 0);
          end else begin
            e = exp_r.pop_front();
            chk("r_port", i, e.port);
            chk("r_id", in_RID, e.id);
            chk("r_data", in_RDATA, e.data);
            chk("r_last", in_RLAST, e.last);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ap_rst      = 1'b1;
    in_ARVALID  = '0;
    in_ARADDR   = '0;
    in_ARLEN    = '0;
    in_ARSIZE   = '0;
    in_ARBURST  = '0;
    in_ARID     = '0;
    in_RREADY   = '0;
    out_ARREADY = 1'b0;
    out_RVALID  = 1'b0;
    out_RDATA   = '0;
    out_RLAST   = 1'b0;
    out_RRESP   = 2'b00;
    out_RID     = 8'hEE;
    repeat (3) step();

    // Reset state
    chk("rst_arvalid", out_ARVALID, 0);
    chk("rst_payload", {out_ARADDR, out_ARLEN, out_ARSIZE, out_ARBURST, out_ARID}, 0);
    chk("rst_arready", in_ARREADY, 0);
    chk("rst_rvalid", in_RVALID, 0);
    chk("rst_rready", out_RREADY, 0);
    ap_rst = 1'b0;
    step();

    // All four requesters continuously valid: grants 0,1,2,3,0
    out_ARREADY = 1'b1;
    for (int p = 0; p < NP; p++) req(p, 32'h1000 + 32'(p) * 32'h100, 8'd0, 8'h10 + 8'(p));
    for (int k = 0; k < 5; k++) begin
      expect_grant(k % NP);
      step();
    end
    in_ARVALID = '0;
    step();

    // Drain the five single-beat bursts in issue order
    in_RREADY = '1;
    for (int k = 0; k < 5; k++) begin
      drive_beat(DW'(k + 1), 1'b1);
      chk("rready_drain", out_RREADY, 1);
      step();
    end
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;

    // Requester 2, ARID 0x5A, 4-beat burst
    req(2, 32'h2000, 8'd3, 8'h5A);
    expect_grant(2);
    step();
    in_ARVALID = '0;
    step();
    for (int b = 0; b < 4; b++) begin
      drive_beat(DW'(32'hA0 + 32'(b)), b == 3);
      chk("rid_5a", in_RID, 8'h5A);
      step();
    end
    out_RVALID = 1'b1;
    out_RLAST  = 1'b1;
    #1;
    chk("empty_rready", out_RREADY, 0);
    chk("empty_rvalid", in_RVALID, 0);
    step();
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;

    // Fill all 16 outstanding slots from port 0; the 17th waits for a pop
    for (int k = 0; k < 16; k++) begin
      req(0, 32'h5000 + 32'(k) * 32'h40, 8'd0, 8'(k));
      expect_grant(0);
      step();
    end
    req(0, 32'h6000, 8'd0, 8'h77);
    expect_grant(-1);
    step();
    expect_grant(-1);
    drive_beat(DW'(32'h500), 1'b1);
    expect_grant(-1);
    step();
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;
    expect_grant(0);
    step();
    in_ARVALID = '0;
    step();
    for (int k = 0; k < 16; k++) begin
      drive_beat(DW'(32'h100 + 32'(k)), 1'b1);
      step();
    end
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;

    // Master AR stall: register full, payload stable, release transfers and regrants
    out_ARREADY = 1'b0;
    req(1, 32'h3000, 8'd0, 8'h07);
    expect_grant(1);
    step();
    in_ARVALID = '0;
    req(3, 32'h4000, 8'd0, 8'h33);
    expect_grant(-1);
    chk("stall_addr0", out_ARADDR, 32'h3000);
    step();
    expect_grant(-1);
    chk("stall_addr1", out_ARADDR, 32'h3000);
    out_ARREADY = 1'b1;
    expect_grant(3);
    step();
    in_ARVALID = '0;
    step();

    // Requester not ready holds the beat; then AR push and RLAST pop together
    in_RREADY  = '0;
    out_RVALID = 1'b1;
    out_RLAST  = 1'b1;
    out_RDATA  = DW'(32'hBEEF);
    #1;
    chk("hold_rvalid", in_RVALID, 4'b0010);
    chk("hold_rready", out_RREADY, 0);
    step();
    chk("hold_rready2", out_RREADY, 0);
    in_RREADY = '1;
    req(0, 32'h7000, 8'd0, 8'h44);
    drive_beat(DW'(32'hBEEF), 1'b1);
    expect_grant(0);
    step();
    in_ARVALID = '0;
    drive_beat(DW'(32'h1), 1'b1);
    step();
    drive_beat(DW'(32'h2), 1'b1);
    step();
    #1;
    chk("pushpop_empty", out_RREADY, 0);
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;
    step();

    // Reset mid-burst, then fresh requests arbitrate from ptr=0
    out_ARREADY = 1'b0;
    req(2, 32'h8000, 8'd3, 8'h66);
    expect_grant(2);
    step();
    in_ARVALID = '0;
    drive_beat(DW'(32'hC0), 1'b0);
    step();
    in_RREADY = '0;
    ap_rst    = 1'b1;
    step();
    chk("mid_rst_arvalid", out_ARVALID, 0);
    chk("mid_rst_rvalid", in_RVALID, 0);
    chk("mid_rst_rready", out_RREADY, 0);
    exp_ar.delete();
    tagq.delete();
    ap_rst      = 1'b0;
    out_RVALID  = 1'b0;
    out_RLAST   = 1'b0;
    out_ARREADY = 1'b1;
    in_RREADY   = '1;
    req(1, 32'h9000, 8'd0, 8'h01);
    req(3, 32'h9100, 8'd0, 8'h03);
    expect_grant(1);
    step();
    in_ARVALID[1] = 1'b0;
    expect_grant(3);
    step();
    in_ARVALID = '0;
    step();
    drive_beat(DW'(32'hD1), 1'b1);
    step();
    drive_beat(DW'(32'hD3), 1'b1);
    step();
    out_RVALID = 1'b0;
    out_RLAST  = 1'b0;
    step();

    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("r_queue_drained", exp_r.size(), 0);
    chk("tag_queue_drained", tagq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI4 read master among NUM_PORTS read requesters (kernel-side mmap ports) ahead of an axi_pipeline toward memory. Round-robin arbitration on AR; all forwarded bursts use one fixed ID, so R beats return in issue order and are steered back using an in-order tag FIFO that also restores each requester's original ARID.

## Interface
- NUM_PORTS, 4: requester count, 2..16; IDX_W = max(1, clog2(NUM_PORTS)) localparam
- C_M_AXI_ID_WIDTH, 8: ARID/RID width
- C_M_AXI_ADDR_WIDTH, 32: address width
- C_M_AXI_DATA_WIDTH, 512: RDATA width
- MAX_OUTSTANDING, 16: max accepted-but-unfinished bursts, power of two ≥2
- ap_clk  in  1  clock; all logic rising-edge
- ap_rst  in  1  reset, synchronous, active-high
- in_ARVALID / in_ARREADY  in/out  NUM_PORTS  per-requester AR handshake
- in_ARADDR  in  NUM_PORTS*ADDR_W  requester i at slice [i*ADDR_W +: ADDR_W]; same packing for in_ARLEN (8), in_ARSIZE (3), in_ARBURST (2), in_ARID (ID_W)
- in_RVALID / in_RREADY  out/in  NUM_PORTS  per-requester R handshake
- in_RDATA, in_RLAST, in_RRESP, in_RID  out  DATA_W, 1, 2, ID_W  shared broadcast to all requesters
- out_ARVALID / out_ARREADY  out/in  1  master AR handshake
- out_ARADDR, out_ARLEN, out_ARSIZE, out_ARBURST, out_ARID  out  ADDR_W, 8, 3, 2, ID_W  registered AR payload; out_ARID constant 0
- out_RVALID / out_RREADY  in/out  1  master R handshake
- out_RDATA, out_RLAST, out_RRESP, out_RID  in  DATA_W, 1, 2, ID_W  out_RID ignored

## Operation
- AR stage: one output register (valid + payload). Accept slot free when register empty, or out_ARVALID && out_ARREADY this cycle.
- Grant: when slot free and tag FIFO not full (count < MAX_OUTSTANDING), grant first requester with in_ARVALID starting at priority pointer ptr, scanning upward with wrap. in_ARREADY[g]=1 for granted g only; all others 0. Combinational from in_ARVALID, ptr, slot, count.
- On accept: load register with requester g payload; push tag {g, in_ARID[g]}; ptr <= (g+1) mod NUM_PORTS. No accept: ptr holds.
- Full FIFO blocks grant even if a pop occurs same cycle (no push-through-pop).
- R steering: head tag {h, id}. in_RVALID[h] = out_RVALID && !empty; others 0. out_RREADY = !empty && in_RREADY[h]. in_RID = id; data/last/resp pass through combinationally.
- Pop on out_RVALID && out_RREADY && out_RLAST. Push and pop same cycle: count unchanged.
- R beat while FIFO empty: out_RREADY=0, no in_RVALID asserted (stall; protocol error upstream).
- ap_rst: ptr=0, AR register invalid, FIFO empty, count=0. Reset mid-burst discards outstanding tags; memory side must reset concurrently.

## Timing
- Reset values: out_ARVALID=0, out_ARADDR/LEN/SIZE/BURST=0, out_ARID=0, in_ARREADY=0, in_RVALID=0, out_RREADY=0.
- AR latency: in_ARVALID&&in_ARREADY at cycle t -> out_ARVALID at t+1. Back-to-back accepts every cycle while out_ARREADY=1.
- R path: zero latency, purely combinational from FIFO head and master R signals.
- Next burst's first beat routable cycle after previous RLAST pop (head updates registered).
- Tag FIFO: count width clog2(MAX_OUTSTANDING)+1; read/write pointers wrap modulo MAX_OUTSTANDING.

## Structure
- No shared package; IDX_W and tag width (IDX_W+ID_W) are localparams.
- One sub-module: axi_read_arbiter_tag_fifo (synchronous FIFO, register array, head visible combinationally, full/empty/count outputs, same ap_clk/ap_rst).
- Round-robin grant as a function/always block in top.

## Test plan
- All 4 requesters assert ARVALID continuously, out_ARREADY=1 -> grants 0,1,2,3,0 on consecutive cycles; out_ARADDR follows with 1-cycle lag.
- Requester 2 ARID=0x5A ARLEN=3, master returns 4 beats -> only in_RVALID[2] asserts, in_RID=0x5A, FIFO pops on 4th beat (RLAST).
- Issue 16 bursts without R -> 17th ARVALID sees in_ARREADY=0; one RLAST pop -> accepted next cycle.
- out_ARREADY held 0 with register full -> in_ARREADY all 0, payload stable; release -> transfer and new grant same cycle.
- in_RREADY[h]=0 during beat -> out_RREADY=0, beat held; simultaneous AR push and RLAST pop -> count unchanged.
- ap_rst asserted mid-burst -> next cycle out_ARVALID=0, in_RVALID=0, ptr=0; fresh request from port 3 granted normally.
